// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory, with lockable ownership and registered read return.
// Optional feature: define DMEM_ARB_RR_EN for round-robin IDLE priority (default build: fixed A over B).
module dmem_arbiter #(
    parameter int LOCK_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_lock,
    input  logic [3:0]  a_we,
    input  logic [13:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_lock,
    input  logic [3:0]  b_we,
    input  logic [13:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [13:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic             PORT_A  = 1'b0;
    localparam logic             PORT_B  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;
    logic             last_reg, last_next;
    logic             forced_next;
    logic             prio_b;
    logic             gnt_a, gnt_b;

`ifdef DMEM_ARB_RR_EN
    assign prio_b = (last_reg == PORT_A);
`else
    // Remembers a forced release for one cycle so the starved port gets a turn.
    logic release_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            release_reg <= 1'b0;
        end else begin
            release_reg <= forced_next;
        end
    end

    assign prio_b = release_reg && (last_reg == PORT_A);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            lock_cnt_reg <= '0;
            last_reg     <= PORT_B;
        end else begin
            state_reg    <= state_next;
            lock_cnt_reg <= lock_cnt_next;
            last_reg     <= last_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        lock_cnt_next = lock_cnt_reg;
        last_next     = last_reg;
        forced_next   = 1'b0;
        gnt_a         = 1'b0;
        gnt_b         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (b_req && (prio_b || !a_req)) begin
                    gnt_b     = 1'b1;
                    last_next = PORT_B;
                    if (b_lock) begin
                        state_next    = OWN_B;
                        lock_cnt_next = CNT_ONE;
                    end
                end else if (a_req) begin
                    gnt_a     = 1'b1;
                    last_next = PORT_A;
                    if (a_lock) begin
                        state_next    = OWN_A;
                        lock_cnt_next = CNT_ONE;
                    end
                end
            end
            OWN_A: begin
                if (lock_cnt_reg == CNT_MAX) begin
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                    last_next     = PORT_A;
                    forced_next   = 1'b1;
                end else if (!a_lock) begin
                    // Dropping the lock still lets a same-cycle request through.
                    gnt_a         = a_req;
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                    if (a_req) begin
                        last_next = PORT_A;
                    end
                end else if (a_req) begin
                    gnt_a         = 1'b1;
                    lock_cnt_next = lock_cnt_reg + CNT_ONE;
                    last_next     = PORT_A;
                end
            end
            OWN_B: begin
                if (lock_cnt_reg == CNT_MAX) begin
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                    last_next     = PORT_B;
                    forced_next   = 1'b1;
                end else if (!b_lock) begin
                    gnt_b         = b_req;
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                    if (b_req) begin
                        last_next = PORT_B;
                    end
                end else if (b_req) begin
                    gnt_b         = 1'b1;
                    lock_cnt_next = lock_cnt_reg + CNT_ONE;
                    last_next     = PORT_B;
                end
            end
            default: begin
                state_next    = IDLE;
                lock_cnt_next = '0;
            end
        endcase
        if (rst) begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end
    end

    assign a_gnt  = gnt_a;
    assign b_gnt  = gnt_b;
    assign mem_en = gnt_a | gnt_b;

    always_comb begin
        mem_we   = '0;
        mem_addr = '0;
        mem_din  = '0;
        if (gnt_a) begin
            mem_we   = a_we;
            mem_addr = a_addr;
            mem_din  = a_wdata;
        end else if (gnt_b) begin
            mem_we   = b_we;
            mem_addr = b_addr;
            mem_din  = b_wdata;
        end
    end

    // Per-port read return: index 0 is port A, index 1 is port B.
    logic        port_rd   [2];
    logic        rvalid_reg[2];
    logic [31:0] rdata_reg [2];

    assign port_rd[0] = gnt_a && (a_we == 4'h0);
    assign port_rd[1] = gnt_b && (b_we == 4'h0);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid_reg[gi] <= 1'b0;
                    rdata_reg[gi]  <= '0;
                end else begin
                    rvalid_reg[gi] <= port_rd[gi];
                    if (port_rd[gi]) begin
                        rdata_reg[gi] <= mem_dout;
                    end
                end
            end
        end
    endgenerate

    assign a_rvalid = rvalid_reg[0];
    assign a_rdata  = rdata_reg[0];
    assign b_rvalid = rvalid_reg[1];
    assign b_rdata  = rdata_reg[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a per-cycle reference model of the grant rules and memory contents.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int LOCK_MAX = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_lock = 1'b0;
    logic [3:0]  a_we = 4'h0;
    logic [13:0] a_addr = 14'h0;
    logic [31:0] a_wdata = 32'h0;
    logic        b_req = 1'b0, b_lock = 1'b0;
    logic [3:0]  b_we = 4'h0;
    logic [13:0] b_addr = 14'h0;
    logic [31:0] b_wdata = 32'h0;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_din, mem_dout;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    bit chk_on    = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.LOCK_MAX(LOCK_MAX), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Memory seen by the DUT, and the image the model expects it to hold.
    logic [31:0] dmem    [4096];
    logic [31:0] ref_mem [4096];
    assign mem_dout = dmem[mem_addr[13:2]];
    always @(posedge clk) begin
        if (mem_en && mem_we != 4'h0) dmem[mem_addr[13:2]] <= merge(dmem[mem_addr[13:2]], mem_we, mem_din);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Model state: owner -1 none / 0 A / 1 B, streak = grants in the current locked run.
    int          owner = -1;
    int          streak = 0;
    int          last = 1;
    bit          just_forced = 1'b0;
    bit          exp_rv [2] = '{1'b0, 1'b0};
    logic [31:0] exp_rd [2] = '{32'h0, 32'h0};

    always @(negedge clk) begin : cmp
        int          g;
        bit          forced_now;
        bit          rq [2];
        bit          lk [2];
        logic [3:0]  w  [2];
        logic [13:0] ad [2];
        logic [31:0] wd [2];
        cyc++;
        rq[0] = a_req;  rq[1] = b_req;
        lk[0] = a_lock; lk[1] = b_lock;
        w[0]  = a_we;   w[1]  = b_we;
        ad[0] = a_addr; ad[1] = b_addr;
        wd[0] = a_wdata; wd[1] = b_wdata;
        g = -1;
        if (!rst) begin
            if (owner < 0) begin
                if (rq[0] && rq[1]) begin
`ifdef DMEM_ARB_RR_EN
                    g = (last == 0) ? 1 : 0;
`else
                    g = (just_forced && last == 0) ? 1 : 0;
`endif
                end else if (rq[0]) g = 0;
                else if (rq[1]) g = 1;
            end else if (streak < LOCK_MAX && rq[owner]) begin
                g = owner;
            end
        end
        if (chk_on) begin
            check($sformatf("cyc%0d a_gnt", cyc), a_gnt, (g == 0));
            check($sformatf("cyc%0d b_gnt", cyc), b_gnt, (g == 1));
            check($sformatf("cyc%0d mem_en", cyc), mem_en, (g >= 0));
            check($sformatf("cyc%0d mem_we", cyc), mem_we, (g >= 0) ? w[g] : 4'h0);
            check($sformatf("cyc%0d mem_addr", cyc), mem_addr, (g >= 0) ? ad[g] : 14'h0);
            check($sformatf("cyc%0d mem_din", cyc), mem_din, (g >= 0) ? wd[g] : 32'h0);
            check($sformatf("cyc%0d a_rvalid", cyc), a_rvalid, exp_rv[0]);
            check($sformatf("cyc%0d a_rdata", cyc), a_rdata, exp_rd[0]);
            check($sformatf("cyc%0d b_rvalid", cyc), b_rvalid, exp_rv[1]);
            check($sformatf("cyc%0d b_rdata", cyc), b_rdata, exp_rd[1]);
        end
        if (rst) begin
            owner = -1; streak = 0; last = 1; just_forced = 1'b0;
            exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
            exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        end else begin
            forced_now = 1'b0;
            exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
            if (owner < 0) begin
                if (g >= 0 && lk[g]) begin owner = g; streak = 1; end
            end else if (streak >= LOCK_MAX) begin
                owner = -1; streak = 0; forced_now = 1'b1;
            end else if (!lk[owner]) begin
                owner = -1; streak = 0;
            end else if (rq[owner]) begin
                streak++;
            end
            just_forced = forced_now;
            if (g >= 0) begin
                last = g;
                if (w[g] == 4'h0) begin
                    exp_rv[g] = 1'b1;
                    exp_rd[g] = ref_mem[ad[g][13:2]];
                end else begin
                    ref_mem[ad[g][13:2]] = merge(ref_mem[ad[g][13:2]], w[g], wd[g]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_req = 1'b0; a_lock = 1'b0; a_we = 4'h0; a_addr = 14'h0; a_wdata = 32'h0;
        b_req = 1'b0; b_lock = 1'b0; b_we = 4'h0; b_addr = 14'h0; b_wdata = 32'h0;
    endtask

    // Presents one access on a port and holds it until granted; returns cycles spent waiting.
    task automatic access(input int port, input logic [3:0] we, input logic [13:0] addr,
                          input logic [31:0] wd, output int waited);
        waited = 0;
        if (port == 0) begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
        else begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
        #1;
        while (!((port == 0) ? a_gnt : b_gnt) && waited < 50) begin
            tick(); #1; waited++;
        end
        if (waited >= 50) begin
            total_cnt++;
            $display("FAIL access_timeout port %0d: no gnt after %0d cycles, required within 50", port, waited);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited, na, nb;
        for (int i = 0; i < 4096; i++) begin dmem[i] = 32'h0; ref_mem[i] = 32'h0; end
        rst = 1'b1;
        a_req = 1'b1;
        a_addr = 14'h010;
        tick();
        chk_on = 1'b1;
        #1;
        check("rst_a_gnt", a_gnt, 0);
        check("rst_mem_en", mem_en, 0);
        tick();
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_a_rdata", a_rdata, 32'h0);
        rst = 1'b0;
        clear_inputs();
        tick();

        // Full-word write then read on A.
        access(0, 4'hF, 14'h010, 32'hDEADBEEF, waited);
        check("t1_wr_wait", waited, 0);
        access(0, 4'h0, 14'h010, 32'h0, waited);
        check("t1_rd_wait", waited, 0);
        check("t1_a_rvalid", a_rvalid, 1);
        check("t1_a_rdata", a_rdata, 32'hDEADBEEF);
        tick();
        check("t1_a_rvalid_pulse", a_rvalid, 0);
        check("t1_a_rdata_hold", a_rdata, 32'hDEADBEEF);

        // Single byte-lane write on B.
        access(1, 4'b0100, 14'h010, 32'h00AA0000, waited);
        access(1, 4'h0, 14'h010, 32'h0, waited);
        check("t2_b_rvalid", b_rvalid, 1);
        check("t2_b_rdata", b_rdata, 32'hDEAABEEF);

        // Unaligned low address bits pass straight through.
        a_req = 1'b1; a_addr = 14'h013;
        #1;
        check("t2_addr_lsb", mem_addr, 14'h013);
        tick();
        clear_inputs();
        check("t2_unaligned_rdata", a_rdata, 32'hDEAABEEF);
        tick();

        // Both ports reading, no lock, four cycles.
        a_req = 1'b1; a_addr = 14'h010;
        b_req = 1'b1; b_addr = 14'h020;
        na = 0; nb = 0;
        for (int k = 0; k < 4; k++) begin
            #1; na += a_gnt; nb += b_gnt; tick();
        end
        clear_inputs();
`ifdef DMEM_ARB_RR_EN
        check("t3_a_grants", na, 2);
        check("t3_b_grants", nb, 2);
`else
        check("t3_a_grants", na, 4);
        check("t3_b_grants", nb, 0);
`endif
        tick();

        // A locks with continuous reads while B waits: lock limit forces a release.
        a_req = 1'b1; a_lock = 1'b1; a_addr = 14'h010;
        na = 0; nb = 0;
        #1; na += a_gnt; nb += b_gnt; tick();
        b_req = 1'b1; b_addr = 14'h020;
        for (int k = 0; k < LOCK_MAX - 1; k++) begin
            #1; na += a_gnt; nb += b_gnt; tick();
        end
        check("t4_a_grants", na, LOCK_MAX);
        check("t4_b_grants", nb, 0);
        #1;
        check("t4_gap_a_gnt", a_gnt, 0);
        check("t4_gap_b_gnt", b_gnt, 0);
        tick(); #1;
        check("t4_after_b_gnt", b_gnt, 1);
        check("t4_after_a_gnt", a_gnt, 0);
        tick();
        clear_inputs();
        tick();

        // A holds the lock across request gaps; B must stay blocked until the lock drops.
        a_req = 1'b1; a_lock = 1'b1; a_addr = 14'h010;
        b_req = 1'b1; b_addr = 14'h020;
        #1; check("t5_first_a_gnt", a_gnt, 1);
        tick();
        na = 0; nb = 0;
        for (int k = 0; k < 8; k++) begin
            a_req = k[0];
            #1; na += a_gnt; nb += b_gnt; tick();
        end
        check("t5_a_grants", na, 4);
        check("t5_b_blocked", nb, 0);
        a_req = 1'b0; a_lock = 1'b0;
        #1; check("t5_release_b_gnt", b_gnt, 0);
        tick(); #1;
        check("t5_next_b_gnt", b_gnt, 1);
        tick();
        clear_inputs();
        tick();

        // Reset while A owns the memory with a read in flight.
        a_req = 1'b1; a_lock = 1'b1; a_addr = 14'h010;
        #1; check("t6_lock_a_gnt", a_gnt, 1);
        tick();
        rst = 1'b1;
        #1;
        check("t6_rst_a_gnt", a_gnt, 0);
        check("t6_rst_mem_en", mem_en, 0);
        check("t6_rst_mem_we", mem_we, 4'h0);
        tick();
        check("t6_a_rvalid", a_rvalid, 0);
        check("t6_a_rdata", a_rdata, 32'h0);
        rst = 1'b0;
        clear_inputs();
        b_req = 1'b1; b_addr = 14'h010;
        #1; check("t6_idle_b_gnt", b_gnt, 1);
        tick();
        clear_inputs();
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
